// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide sequencer.
package muldiv_pkg;

    // funct3 encoding of the M-extension ops
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    // Control codes understood by the shared ALU
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [3:0] ALU_GEU = 4'b1111;  // subtract, flag = (n1 >= n2) unsigned

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_NEGA  = 3'd1,
        ST_NEGB  = 3'd2,
        ST_ITER  = 3'd3,
        ST_FIXLO = 3'd4,
        ST_FIXHI = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    // rs1 is treated as signed
    function automatic logic op_signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is treated as signed
    function automatic logic op_signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Result comes from the hi/rem half of the accumulator
    function automatic logic op_res_hi(input logic [2:0] op);
        return !((op == OP_MUL) || (op == OP_DIV) || (op == OP_DIVU));
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer that borrows the shared ALU for every arithmetic step.
// Accumulator layout: multiply {hi,lo}; divide hi = remainder, lo = quotient.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [2:0]   i_op,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_result,
    output logic [3:0]   o_alu_ctrl,
    output logic [W-1:0] o_alu_n1,
    output logic [W-1:0] o_alu_n2,
    input  logic [W-1:0] i_alu_dout,
    input  logic         i_alu_flag
);

    localparam int unsigned CW = $clog2(W);

    state_e         r_state, w_state_d;
    logic [2:0]     r_op, w_op_d;
    logic [W-1:0]   r_a, w_a_d;          // |a| once NEGA has run
    logic [W-1:0]   r_b, w_b_d;          // |b| once NEGB has run
    logic [W-1:0]   r_hi, w_hi_d;
    logic [W-1:0]   r_lo, w_lo_d;
    logic [CW-1:0]  r_cnt, w_cnt_d;
    logic           r_negr, w_negr_d;    // final result must be negated
    logic           r_negb, w_negb_d;    // NEGB still pending after NEGA
    logic [W-1:0]   r_result, w_result_d;
    logic [W-1:0]   w_s;
    logic           w_q;
    logic           w_carry;
    logic           w_sa;
    logic           w_sb;

    // Next-state, datapath update and ALU drive
    always_comb begin
        w_state_d  = r_state;
        w_op_d     = r_op;
        w_a_d      = r_a;
        w_b_d      = r_b;
        w_hi_d     = r_hi;
        w_lo_d     = r_lo;
        w_cnt_d    = r_cnt;
        w_negr_d   = r_negr;
        w_negb_d   = r_negb;
        w_result_d = r_result;
        w_s        = '0;
        w_q        = 1'b0;
        w_carry    = 1'b0;
        w_sa       = op_signed_a(i_op) & i_a[W-1];
        w_sb       = op_signed_b(i_op) & i_b[W-1];
        o_alu_ctrl = ALU_ADD;
        o_alu_n1   = '0;
        o_alu_n2   = '0;

        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                w_state_d = ST_IDLE;
                if (i_start) begin
                    w_op_d   = i_op;
                    w_a_d    = i_a;
                    w_b_d    = i_b;
                    w_hi_d   = '0;
                    w_lo_d   = i_op[2] ? i_a : i_b;
                    w_cnt_d  = '0;
                    w_negb_d = w_sb;
                    unique case (i_op)
                        OP_MULH, OP_DIV: w_negr_d = i_a[W-1] ^ i_b[W-1];
                        OP_MULHSU, OP_REM: w_negr_d = i_a[W-1];
                        default: w_negr_d = 1'b0;
                    endcase
                    if (i_op[2] && (i_b == '0)) begin
                        // Divide by zero: quotient all-ones, remainder = dividend
                        w_state_d  = ST_DONE;
                        w_result_d = i_op[1] ? i_a : '1;
                    end else if (((i_op == OP_DIV) || (i_op == OP_REM)) &&
                                 (i_a == {1'b1, {(W-1){1'b0}}}) && (i_b == '1)) begin
                        // Signed overflow: quotient = dividend, remainder = 0
                        w_state_d  = ST_DONE;
                        w_result_d = (i_op == OP_DIV) ? i_a : '0;
                    end else if (w_sa) begin
                        w_state_d = ST_NEGA;
                    end else if (w_sb) begin
                        w_state_d = ST_NEGB;
                    end else begin
                        w_state_d = ST_ITER;
                    end
                end
            end
            ST_NEGA: begin
                o_alu_ctrl = ALU_SUB;
                o_alu_n2   = r_a;
                w_a_d      = i_alu_dout;
                if (r_op[2]) w_lo_d = i_alu_dout;
                w_state_d  = r_negb ? ST_NEGB : ST_ITER;
            end
            ST_NEGB: begin
                o_alu_ctrl = ALU_SUB;
                o_alu_n2   = r_b;
                w_b_d      = i_alu_dout;
                if (!r_op[2]) w_lo_d = i_alu_dout;
                w_state_d  = ST_ITER;
            end
            ST_ITER: begin
                if (r_op[2]) begin
                    // Restoring divide step; rem[W-1] stands in for the shifted-out bit W
                    w_s        = {r_hi[W-2:0], r_lo[W-1]};
                    o_alu_ctrl = ALU_GEU;
                    o_alu_n1   = w_s;
                    o_alu_n2   = r_b;
                    w_q        = i_alu_flag | r_hi[W-1];
                    w_hi_d     = w_q ? i_alu_dout : w_s;
                    w_lo_d     = {r_lo[W-2:0], w_q};
                end else begin
                    // Shift-add multiply step; carry rebuilt from the operand/sum MSBs
                    o_alu_ctrl = ALU_ADD;
                    o_alu_n1   = r_hi;
                    o_alu_n2   = r_a;
                    w_carry    = (r_hi[W-1] & r_a[W-1]) |
                                 ((r_hi[W-1] | r_a[W-1]) & ~i_alu_dout[W-1]);
                    if (r_lo[0]) begin
                        w_hi_d = {w_carry, i_alu_dout[W-1:1]};
                        w_lo_d = {i_alu_dout[0], r_lo[W-1:1]};
                    end else begin
                        w_hi_d = {1'b0, r_hi[W-1:1]};
                        w_lo_d = {r_hi[0], r_lo[W-1:1]};
                    end
                end
                w_cnt_d = r_cnt + CW'(1);
                if (r_cnt == CW'(W - 1)) begin
                    if (r_negr) begin
                        w_state_d = ST_FIXLO;
                    end else begin
                        w_state_d  = ST_DONE;
                        w_result_d = op_res_hi(r_op) ? w_hi_d : w_lo_d;
                    end
                end
            end
            ST_FIXLO: begin
                // Only REM negates the hi half here; every other op negates lo first
                o_alu_ctrl = ALU_SUB;
                if (r_op == OP_REM) begin
                    o_alu_n2 = r_hi;
                    w_hi_d   = i_alu_dout;
                end else begin
                    o_alu_n2 = r_lo;
                    w_lo_d   = i_alu_dout;
                end
                if (!r_op[2]) begin
                    w_state_d = ST_FIXHI;
                end else begin
                    w_state_d  = ST_DONE;
                    w_result_d = op_res_hi(r_op) ? w_hi_d : w_lo_d;
                end
            end
            ST_FIXHI: begin
                // -x of the 64-bit product: hi gets ~hi plus the borrow out of lo (lo==0)
                o_alu_ctrl = ALU_ADD;
                o_alu_n1   = ~r_hi;
                o_alu_n2   = {{(W-1){1'b0}}, (r_lo == '0)};
                w_hi_d     = i_alu_dout;
                w_state_d  = ST_DONE;
                w_result_d = i_alu_dout;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_negr   <= 1'b0;
            r_negb   <= 1'b0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_d;
            r_op     <= w_op_d;
            r_a      <= w_a_d;
            r_b      <= w_b_d;
            r_hi     <= w_hi_d;
            r_lo     <= w_lo_d;
            r_cnt    <= w_cnt_d;
            r_negr   <= w_negr_d;
            r_negb   <= w_negb_d;
            r_result <= w_result_d;
        end
    end

    assign o_busy   = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign o_done   = (r_state == ST_DONE);
    assign o_result = r_result;

endmodule
